// File: rtl/gcram_refresh_arbiter.sv
// gcram_refresh_arbiter: shares RW port 0 of a 1RW+1R gain-cell SRAM between a user and a read/writeback refresh engine
// Ports: clk/rst (sync, active-high); refresh_en gates the refresh timer;
//   req_valid/req_ready/req_we/req_addr/req_wdata form the user request channel;
//   rsp_valid/rsp_rdata return read data one cycle after acceptance;
//   sweep_done pulses once after the last row has been refreshed;
//   csb0/web0/addr0/din0/dout0 drive macro port 0; csb1/addr1/dout1 drive macro port 1.
// Optional macro REFRESH_STATS_EN adds refresh_count and cancel_count outputs.
module gcram_refresh_arbiter #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int REFRESH_INTERVAL = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  refresh_en,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  sweep_done,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0,
  output logic                  csb1,
  output logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] dout1
`ifdef REFRESH_STATS_EN
  ,
  output logic [15:0]           refresh_count,
  output logic [15:0]           cancel_count
`endif
);
  localparam int TW = $clog2(REFRESH_INTERVAL);
  typedef enum logic [1:0] {IDLE, REF_RD, REF_WB} state_t;
  state_t state;
  logic [TW-1:0] timer;
  logic [ADDR_WIDTH-1:0] rf_addr;
  logic cancel, wb, accept, tick;
  // the writeback owns port 0 only when no same-row user write superseded it
  assign wb = !rst && state == REF_WB && !cancel;
  assign req_ready = !rst && !(state == REF_WB && !cancel);
  assign accept = req_valid && req_ready;
  assign tick = refresh_en && timer == TW'(REFRESH_INTERVAL - 1);
  assign csb0 = wb ? 1'b0 : !accept;
  assign web0 = wb ? 1'b0 : !req_we;
  assign addr0 = wb ? rf_addr : req_addr;
  assign din0 = wb ? dout1 : req_wdata;
  assign csb1 = !(!rst && state == REF_RD);
  assign addr1 = rf_addr;
  assign rsp_rdata = dout0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      rf_addr <= '0;
      cancel <= 1'b0;
      rsp_valid <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      if (refresh_en) timer <= tick ? '0 : timer + 1'b1;
      state <= tick ? REF_RD : state == REF_RD ? REF_WB : IDLE;
      // a user write landing on the row being read makes the stale writeback unnecessary
      cancel <= state == REF_RD && accept && req_we && req_addr == rf_addr;
      if (state == REF_WB) rf_addr <= rf_addr + 1'b1;
      rsp_valid <= accept && !req_we;
      sweep_done <= state == REF_WB && rf_addr == '1;
    end
  end
`ifdef REFRESH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_count <= '0;
      cancel_count <= '0;
    end else if (state == REF_WB) begin
      if (!cancel && refresh_count != '1) refresh_count <= refresh_count + 1'b1;
      if (cancel && cancel_count != '1) cancel_count <= cancel_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_gcram_refresh_arbiter.sv
// tb_gcram_refresh_arbiter: directed vector bench with a behavioural 1RW+1R macro
module tb_gcram_refresh_arbiter;
  logic clk = 1'b0;
  logic rst, refresh_en, req_valid, req_we;
  logic [3:0] req_addr;
  logic [1:0] req_wdata;
  logic req_ready, rsp_valid, sweep_done, csb0, web0, csb1;
  logic [1:0] rsp_rdata, din0, dout0, dout1;
  logic [3:0] addr0, addr1;
`ifdef REFRESH_STATS_EN
  logic [15:0] refresh_count, cancel_count;
`endif
  logic [1:0] mem [16];
  logic [1:0] exp_mem [16];
  int total = 0;
  int bad = 0;
  typedef struct { int rst, v, we, a, d, rdy, c0, w0, c1, rv, rd; } vec_t;
  vec_t vecs [11];

  gcram_refresh_arbiter #(.DATA_WIDTH(2), .ADDR_WIDTH(4), .REFRESH_INTERVAL(8)) dut (
    .clk(clk), .rst(rst), .refresh_en(refresh_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .sweep_done(sweep_done),
    .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0),
    .csb1(csb1), .addr1(addr1), .dout1(dout1)
`ifdef REFRESH_STATS_EN
    , .refresh_count(refresh_count), .cancel_count(cancel_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!csb0) begin
      if (!web0) mem[addr0] <= din0;
      else dout0 <= mem[addr0];
    end
    if (!csb1) dout1 <= mem[addr1];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    refresh_en = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    next();
    rst = 1'b0;
  endtask

  initial begin
    int i, a, row;
    logic pend, acc, we;
    logic [3:0] pend_addr;
    for (int k = 0; k < 16; k++) begin
      mem[k] = ~2'(k);
      exp_mem[k] = ~2'(k);
    end
    vecs[0]  = '{1, 1, 1, 5, 2, 0, 1, 1, 1, 0, 0};
    vecs[1]  = '{1, 1, 1, 5, 2, 0, 1, 1, 1, 0, 0};
    vecs[2]  = '{0, 1, 1, 5, 2, 1, 0, 0, 1, 0, 0};
    vecs[3]  = '{0, 1, 0, 5, 0, 1, 0, 1, 1, 0, 0};
    vecs[4]  = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 2};
    vecs[5]  = '{0, 1, 1, 3, 1, 1, 0, 0, 1, 0, 0};
    vecs[6]  = '{0, 1, 1, 9, 3, 1, 0, 0, 1, 0, 0};
    vecs[7]  = '{0, 1, 0, 3, 0, 1, 0, 1, 1, 0, 0};
    vecs[8]  = '{0, 1, 0, 9, 0, 1, 0, 1, 1, 1, 1};
    vecs[9]  = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 3};
    vecs[10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    rst = 1'b1;
    refresh_en = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 11; k++) begin
      rst = vecs[k].rst[0];
      req_valid = vecs[k].v[0];
      req_we = vecs[k].we[0];
      req_addr = 4'(vecs[k].a);
      req_wdata = 2'(vecs[k].d);
      @(negedge clk);
      chk($sformatf("vec%0d ready", k), req_ready, vecs[k].rdy);
      chk($sformatf("vec%0d csb0", k), csb0, vecs[k].c0);
      chk($sformatf("vec%0d csb1", k), csb1, vecs[k].c1);
      chk($sformatf("vec%0d rsp_valid", k), rsp_valid, vecs[k].rv);
      if (vecs[k].rv != 0) chk($sformatf("vec%0d rdata", k), rsp_rdata, vecs[k].rd);
      if (vecs[k].c0 == 0) begin
        chk($sformatf("vec%0d web0", k), web0, vecs[k].w0);
        chk($sformatf("vec%0d addr0", k), addr0, vecs[k].a);
        if (vecs[k].we != 0) chk($sformatf("vec%0d din0", k), din0, vecs[k].d);
      end
      if (vecs[k].rst == 0 && vecs[k].v != 0 && vecs[k].we != 0) exp_mem[vecs[k].a] = 2'(vecs[k].d);
      next();
    end

    // refresh cadence over a full sweep plus wrap
    do_reset();
    for (int n = 0; n < 138; n++) begin
      @(negedge clk);
      chk("cad csb1", csb1, !(n % 8 == 0 && n > 0));
      if (n % 8 == 0 && n > 0) chk("cad addr1", addr1, (n / 8 - 1) % 16);
      chk("cad csb0", csb0, !(n % 8 == 1 && n > 1));
      if (n % 8 == 1 && n > 1) begin
        row = ((n - 1) / 8 - 1) % 16;
        chk("cad web0", web0, 0);
        chk("cad addr0", addr0, row);
        chk("cad din0", din0, exp_mem[row]);
      end
      chk("cad sweep", sweep_done, n == 130);
      next();
    end
`ifdef REFRESH_STATS_EN
    chk("cad refresh_count", refresh_count, 17);
`endif

    // continuous requests stall only in writeback cycles
    do_reset();
    i = 0;
    pend = 1'b0;
    pend_addr = '0;
    for (int n = 0; n < 32; n++) begin
      a = (i / 2) % 16;
      we = (i % 2 == 0);
      req_valid = 1'b1;
      req_we = we;
      req_addr = 4'(a);
      req_wdata = 2'(a) + 2'd2;
      @(negedge clk);
      chk("stall ready", req_ready, !(n % 8 == 1 && n > 1));
      chk("stall rsp_valid", rsp_valid, pend);
      if (pend) chk("stall rdata", rsp_rdata, exp_mem[pend_addr]);
      acc = req_ready;
      if (acc && we) exp_mem[a] = 2'(a) + 2'd2;
      pend = acc && !we;
      pend_addr = 4'(a);
      if (acc) i++;
      next();
    end
    chk("stall accepted", i, 29);
    req_valid = 1'b0;

    // same-row write during REF_RD cancels the writeback
    do_reset();
    for (int n = 0; n < 8; n++) next();
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = 4'd0;
    req_wdata = 2'b01;
    @(negedge clk);
    chk("cancel rd csb1", csb1, 0);
    chk("cancel rd addr1", addr1, 0);
    chk("cancel rd ready", req_ready, 1);
    chk("cancel rd csb0", csb0, 0);
    chk("cancel rd web0", web0, 0);
    exp_mem[0] = 2'b01;
    next();
    req_valid = 1'b0;
    @(negedge clk);
    chk("cancel wb ready", req_ready, 1);
    chk("cancel wb csb0", csb0, 1);
    next();
    req_valid = 1'b1;
    req_we = 1'b0;
    @(negedge clk);
    chk("cancel read web0", web0, 1);
`ifdef REFRESH_STATS_EN
    chk("cancel_count", cancel_count, 1);
    chk("cancel refresh_count", refresh_count, 0);
`endif
    next();
    req_valid = 1'b0;
    @(negedge clk);
    chk("cancel rsp_valid", rsp_valid, 1);
    chk("cancel rdata", rsp_rdata, exp_mem[0]);
    next();

    // reset during REF_WB of row 1 abandons the writeback
    do_reset();
    for (int n = 0; n < 17; n++) next();
    rst = 1'b1;
    @(negedge clk);
    chk("rstwb csb0", csb0, 1);
    chk("rstwb ready", req_ready, 0);
    chk("rstwb csb1", csb1, 1);
    next();
    rst = 1'b0;
    for (int n = 0; n < 9; n++) begin
      @(negedge clk);
      chk("rstwb after csb1", csb1, n != 8);
      chk("rstwb after csb0", csb0, 1);
      if (n == 8) chk("rstwb after addr1", addr1, 0);
      next();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
